// File: rtl/qspi_flash_arbiter_pkg.sv
// Shared constants for the QSPI flash subsystem: arbiter state encoding and
// default grant hold limit.
package qspi_flash_arbiter_pkg;

  localparam int unsigned HoldTimeoutDefault = 4096;
  localparam int unsigned NumReq = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e own_state(input logic id);
    return id ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/qspi_flash_arbiter_if.sv
// QSPI read-port bundle between a page buffer and the flash device (or arbiter).
interface qspi_flash_arbiter_if;
  logic        enable;
  logic        request;
  logic [23:0] address;
  logic        change_address;
  logic        request_data;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        initialised;
  logic        busy;

  // Requester side of the port.
  modport master (
    output enable, request, address, change_address, request_data,
    input  read_data, read_data_valid, initialised, busy
  );

  // Arbiter side facing a requester.
  modport slave (
    input  enable, request, address, change_address, request_data,
    output read_data, read_data_valid, initialised, busy
  );

  // Arbiter side facing the device; the device has no notion of ownership requests.
  modport dev (
    output enable, address, change_address, request_data,
    input  read_data, read_data_valid, initialised, busy
  );
endinterface

// File: rtl/qspi_flash_arbiter.sv
// Round-robin arbiter sharing one QSPI flash read device between two page buffers,
// with whole-burst ownership and a forced release on hold timeout.
module qspi_flash_arbiter
  import qspi_flash_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_TIMEOUT = HoldTimeoutDefault
) (
  input  logic                       clk,
  input  logic                       rst,
  qspi_flash_arbiter_if.slave        req0,
  qspi_flash_arbiter_if.slave        req1,
  qspi_flash_arbiter_if.dev          qspi,
  output logic                       owner_valid,
  output logic                       owner_id,
  output logic [1:0]                 timeout_error
);

  localparam int unsigned CntW = (HOLD_TIMEOUT == 0) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = (HOLD_TIMEOUT == 0) ? '0 : CntW'(HOLD_TIMEOUT - 1);

  logic [NumReq-1:0] en, rq, chg, rqd, own, want, busy_v, rdv_v;
  logic [23:0]       addr   [NumReq];
  logic [23:0]       addr_m [NumReq];

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        tmo_q, tmo_d;
  logic              cur, grant, hit_timeout, normal_release;

  assign en   = {req1.enable, req0.enable};
  assign rq   = {req1.request, req0.request};
  assign chg  = {req1.change_address, req0.change_address};
  assign rqd  = {req1.request_data, req0.request_data};
  assign addr[0] = req0.address;
  assign addr[1] = req1.address;

  assign own  = {state_q == StOwn1, state_q == StOwn0};
  assign cur  = own[1];
  assign want = en & rq;

  assign hit_timeout    = (HOLD_TIMEOUT != 0) && (cnt_q == CntLast);
  assign normal_release = !rq[cur] && !rqd[cur] && !chg[cur] && !qspi.busy;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    tmo_d   = tmo_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (want != '0) begin
          // On a tie the requester that did not own last time wins.
          grant   = (want == 2'b11) ? ~last_q : want[1];
          state_d = own_state(grant);
          last_d  = grant;
        end
      end
      StOwn0, StOwn1: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (hit_timeout) tmo_d[cur] = 1'b1;
        if (!en[cur] || hit_timeout || normal_release) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  for (genvar n = 0; n < NumReq; n++) begin : g_req
    assign busy_v[n] = own[n] ? qspi.busy : 1'b1;
    assign rdv_v[n]  = own[n] & qspi.read_data_valid;
    assign addr_m[n] = own[n] ? addr[n] : '0;
  end

  assign qspi.enable         = |en;
  assign qspi.address        = addr_m[0] | addr_m[1];
  assign qspi.change_address = |(own & chg);
  assign qspi.request_data   = |(own & rqd);

  assign req0.read_data       = qspi.read_data;
  assign req1.read_data       = qspi.read_data;
  assign req0.initialised     = qspi.initialised;
  assign req1.initialised     = qspi.initialised;
  assign req0.busy            = busy_v[0];
  assign req1.busy            = busy_v[1];
  assign req0.read_data_valid = rdv_v[0];
  assign req1.read_data_valid = rdv_v[1];

  assign owner_valid   = (state_q != StIdle);
  assign owner_id      = cur;
  assign timeout_error = tmo_q;

endmodule

// File: doc/qspi_flash_arbiter.md
# qspi_flash_arbiter

- Shares one QSPI flash read device between two flash page-buffer requesters, for example an instruction-side buffer and a data-side buffer.
- Sits between the buffers' QSPI ports and the single QSPI device.
- Grants exclusive ownership for a whole page-fill burst, chosen round-robin, and muxes the address and control signals.
- Forces release of an owner that holds the device too long, and reports it.

## Interface
Parameters:
- HOLD_TIMEOUT, default 4096: maximum cycles one grant may be held. 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- reqN_enable  in  1  requester N (N=0,1) wants the QSPI device enabled
- reqN_request  in  1  requester N needs an address change, i.e. wants ownership
- reqN_address  in  24  page load address of requester N
- reqN_changeAddress  in  1  requester N address-change strobe
- reqN_requestData  in  1  requester N is in a burst read
- reqN_readData  out  32  read data, broadcast to both requesters
- reqN_readDataValid  out  1  read-data valid, delivered to the owner only
- reqN_initialised  out  1  device initialised, broadcast
- reqN_busy  out  1  busy to requester N (qspi_busy if N is owner, else 1)
- qspi_enable  out  1  req0_enable | req1_enable
- qspi_address  out  24  owner's address, 0 when idle
- qspi_changeAddress  out  1  owner's changeAddress, 0 when idle
- qspi_requestData  out  1  owner's requestData, 0 when idle
- qspi_readData  in  32  device read data
- qspi_readDataValid  in  1  device data valid
- qspi_initialised  in  1  device initialised
- qspi_busy  in  1  device busy
- owner_valid  out  1  a grant is active
- owner_id  out  1  current owner index
- timeout_error  out  2  sticky: bit N is set when requester N was force-released

## Operation
FSM states: IDLE, OWN0, OWN1. The `last` register holds the last owner.

- **IDLE**
  - If exactly one of `reqN_request && reqN_enable` holds, grant that requester.
  - If both hold, grant the requester that is not `last`.
  - The next state is OWNn and `last` is set to n.
- **OWNn exit conditions.** Go to IDLE when any of these holds:
  - Normal release: `!reqN_request && !reqN_requestData && !reqN_changeAddress && !qspi_busy`.
  - `reqN_enable` falls: immediate release.
  - Hold counter reaches HOLD_TIMEOUT-1 while HOLD_TIMEOUT≠0: release and set `timeout_error[n]`.
- **Hold counter**
  - Width $clog2(HOLD_TIMEOUT+1), minimum 1.
  - Cleared on entry to OWNn; increments every OWNn cycle; saturates.
- **IDLE between grants.** IDLE always lasts at least 1 cycle between grants. There is no direct handoff.
- **Output gating**
  - A non-owner sees `busy=1` and `readDataValid=0`.
  - Non-owner `changeAddress` and `requestData` are ignored.
  - In IDLE both requesters see `busy=1`.
- **timeout_error** clears only on rst.
- **Reset values.** State IDLE, `last=1` so requester 0 wins the first tie, counter 0, `owner_valid=0`, `owner_id=0`, `timeout_error=0`. Every qspi_* output is 0 except `qspi_enable`, which is combinational from the inputs. All `reqN_busy` outputs are 1.
- **rst mid-burst** aborts the grant at once. Reissuing is the requesters' responsibility.

## Timing
- Request seen in IDLE at edge t → OWNn from t+1; `reqN_busy` follows `qspi_busy` combinationally from t+1. The earliest `qspi_changeAddress` is at t+1.
- Mux paths are combinational from the registered state. There is no added latency on data or valid.
- Release condition true at edge t → IDLE at t+1 → next grant at t+2. Ownership gap is exactly 1 cycle.
- Request asserted in the same cycle as the release condition: still released. The other requester wins at t+2 if it is requesting.
- Timeout: grant at cycle g → forced IDLE at g+HOLD_TIMEOUT, with `timeout_error` set in that same cycle.
- `qspi_readDataValid` arriving in IDLE is dropped and not delivered to either requester.

## Structure
- State encoding localparams (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default HOLD_TIMEOUT belong in a shared flash constants include used by the flash subsystem.
- Single module, with no sub-module. The per-requester mux is a generate loop over N=0..1.

## Test plan
1. **Single requester.** rst, then `req0_request=1` for 1 cycle followed by a 512-word burst. Required: `owner_id=0` the cycle after request; exactly 512 `req0_readDataValid`, 0 on req1; IDLE 1 cycle after requestData and busy fall.
2. **Simultaneous requests.** Both assert `request` in the same cycle after reset. Required: req0 is granted first; req1 is granted exactly 2 cycles after req0's release. With both requesting again, req1 then req0 alternate.
3. **Non-owner isolation.** While req0 owns the device, req1 pulses `changeAddress` and `address=0x1000`. Required: `qspi_address` stays req0's; `req1_busy=1` throughout.
4. **Timeout.** HOLD_TIMEOUT=16; req0 holds `requestData=1` indefinitely. Required: IDLE at grant+16, `timeout_error=2'b01`, error still set after a later normal grant.
5. **Enable drop.** req0 owns the device and `req0_enable` falls mid-burst. Required: IDLE next cycle; `qspi_enable` follows `req1_enable`; no valid is delivered to req0 afterwards.
6. **Reset mid-grant.** rst asserted during OWN1. Required: the next cycle is IDLE, `owner_valid=0`, `timeout_error=0`, and every `reqN_busy=1`.
